// File: rtl/hazard_io_sched.sv
// hazard_io_sched: forwarding, load-use stalls, branch flushes and I/O FIFO
// sequencing for the 5-stage core.
`default_nettype none

module hazard_io_sched #(
    parameter logic [2:0] LOAD_SRC = 3'b001,
    parameter int         TIMEOUT  = 1024,
    parameter int         CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic [2:0]       result_src_e,
    input  logic             pc_src_e,
    input  logic [4:0]       rd_m,
    input  logic             reg_write_m,
    input  logic [4:0]       rd_w,
    input  logic             reg_write_w,
    input  logic             in_issued_d,
    input  logic             out_issued_d,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic             in_pop,
    output logic             out_push,
    output logic             io_timeout,
    output logic [CNT_W-1:0] stall_count
);

    localparam int                WCNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COOL     = 2'd1,
        S_WAIT_IN  = 2'd2,
        S_WAIT_OUT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              in_pop_q, in_pop_d;
    logic              out_push_q, out_push_d;
    logic              timeout_q, timeout_d;
    logic [WCNT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic load_stall;
    logic io_stall;
    logic stall;
    logic in_wait;
    logic timeout_hit;

    // Memory stage holds the younger result, so it wins over writeback.
    always_comb begin
        forward_a_e = 2'b00;
        forward_b_e = 2'b00;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs1_e))
            forward_a_e = 2'b10;
        else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs1_e))
            forward_a_e = 2'b01;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs2_e))
            forward_b_e = 2'b10;
        else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs2_e))
            forward_b_e = 2'b01;
    end

    assign load_stall = (result_src_e == LOAD_SRC) && (rd_e != 5'd0) &&
                        ((rd_e == rs1_d) || (rd_e == rs2_d));

    always_comb begin
        io_stall = 1'b0;
        case (state_q)
            S_IDLE:     io_stall = (in_issued_d && !in_valid) ||
                                   (out_issued_d && !out_ready);
            S_COOL:     io_stall = in_issued_d || out_issued_d;
            S_WAIT_IN:  io_stall = !in_valid;
            S_WAIT_OUT: io_stall = !out_ready;
            default:    io_stall = 1'b0;
        endcase
    end

    assign stall   = (load_stall || io_stall) && !pc_src_e;
    assign stall_f = stall;
    assign stall_d = stall;
    assign flush_e = stall || pc_src_e;
    assign flush_d = pc_src_e;

    // A taken branch discards whatever sits in decode, pending I/O included.
    always_comb begin
        state_d    = state_q;
        in_pop_d   = 1'b0;
        out_push_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!pc_src_e) begin
                    if (in_issued_d) begin
                        if (!in_valid) begin
                            state_d = S_WAIT_IN;
                        end else if (!load_stall) begin
                            in_pop_d = 1'b1;
                            state_d  = S_COOL;
                        end
                    end else if (out_issued_d) begin
                        if (!out_ready) begin
                            state_d = S_WAIT_OUT;
                        end else if (!load_stall) begin
                            out_push_d = 1'b1;
                            state_d    = S_COOL;
                        end
                    end
                end
            end
            S_COOL: begin
                state_d = S_IDLE;
                if (!pc_src_e) begin
                    if (in_issued_d) begin
                        if (!in_valid)
                            state_d = S_WAIT_IN;
                    end else if (out_issued_d && !out_ready) begin
                        state_d = S_WAIT_OUT;
                    end
                end
            end
            S_WAIT_IN: begin
                if (pc_src_e) begin
                    state_d = S_IDLE;
                end else if (in_valid && !load_stall) begin
                    in_pop_d = 1'b1;
                    state_d  = S_COOL;
                end
            end
            S_WAIT_OUT: begin
                if (pc_src_e) begin
                    state_d = S_IDLE;
                end else if (out_ready && !load_stall) begin
                    out_push_d = 1'b1;
                    state_d    = S_COOL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The wait counter holds completed wait cycles, so the flag rises on the
    // TIMEOUT-th wait cycle itself and is then latched.
    assign in_wait     = (state_q == S_WAIT_IN) || (state_q == S_WAIT_OUT);
    assign timeout_hit = in_wait && (wait_q == WAIT_LAST);
    assign timeout_d   = timeout_q || timeout_hit;
    assign io_timeout  = timeout_q || timeout_hit;

    always_comb begin
        wait_d = '0;
        if (in_wait)
            wait_d = (wait_q == WAIT_LAST) ? wait_q : wait_q + WCNT_W'(1);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_pop_q    <= 1'b0;
            out_push_q  <= 1'b0;
            timeout_q   <= 1'b0;
            wait_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            in_pop_q    <= in_pop_d;
            out_push_q  <= out_push_d;
            timeout_q   <= timeout_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign in_pop      = in_pop_q;
    assign out_push    = out_push_q;
    assign stall_count = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_io_sched.sv
// Directed self-checking bench for hazard_io_sched (TIMEOUT reduced to 4).
`default_nettype none

module tb_hazard_io_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [2:0]  result_src_e;
    logic        pc_src_e, reg_write_m, reg_write_w;
    logic        in_issued_d, out_issued_d, in_valid, out_ready;
    logic [1:0]  forward_a_e, forward_b_e;
    logic        stall_f, stall_d, flush_d, flush_e;
    logic        in_pop, out_push, io_timeout;
    logic [31:0] stall_count;

    int checks = 0;
    int errors = 0;

    hazard_io_sched #(
        .LOAD_SRC (3'b001),
        .TIMEOUT  (4),
        .CNT_W    (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rs1_d        (rs1_d),
        .rs2_d        (rs2_d),
        .rs1_e        (rs1_e),
        .rs2_e        (rs2_e),
        .rd_e         (rd_e),
        .result_src_e (result_src_e),
        .pc_src_e     (pc_src_e),
        .rd_m         (rd_m),
        .reg_write_m  (reg_write_m),
        .rd_w         (rd_w),
        .reg_write_w  (reg_write_w),
        .in_issued_d  (in_issued_d),
        .out_issued_d (out_issued_d),
        .in_valid     (in_valid),
        .out_ready    (out_ready),
        .forward_a_e  (forward_a_e),
        .forward_b_e  (forward_b_e),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_d      (flush_d),
        .flush_e      (flush_e),
        .in_pop       (in_pop),
        .out_push     (out_push),
        .io_timeout   (io_timeout),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        chk({tag, "_stall_f"}, {31'd0, stall_f}, {31'd0, exp});
        chk({tag, "_stall_d"}, {31'd0, stall_d}, {31'd0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
        result_src_e = 0; pc_src_e = 0; reg_write_m = 0; reg_write_w = 0;
        in_issued_d = 0; out_issued_d = 0; in_valid = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_pop", {31'd0, in_pop}, 32'd0);
        chk("rst_out_push", {31'd0, out_push}, 32'd0);
        chk("rst_timeout", {31'd0, io_timeout}, 32'd0);
        chk("rst_stall_count", stall_count, 32'd0);
        chk("rst_fwd_a", {30'd0, forward_a_e}, 32'd0);
        rst = 1'b0;

        // Forwarding
        rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1; rs1_e = 5; rs2_e = 5;
        #1;
        chk("fwd_a_mem", {30'd0, forward_a_e}, 32'd2);
        chk("fwd_b_mem", {30'd0, forward_b_e}, 32'd2);
        reg_write_m = 0;
        #1;
        chk("fwd_a_wb", {30'd0, forward_a_e}, 32'd1);
        rs2_e = 3;
        #1;
        chk("fwd_b_none", {30'd0, forward_b_e}, 32'd0);
        rs1_e = 0; rd_m = 0; rd_w = 0; reg_write_m = 1;
        #1;
        chk("fwd_a_x0", {30'd0, forward_a_e}, 32'd0);
        rs1_e = 0; rs2_e = 0; reg_write_m = 0; reg_write_w = 0;

        // Load-use: rd_e = x0 never stalls
        result_src_e = 3'b001; rd_e = 0; rs1_d = 0;
        #1;
        chk_stall("load_x0", 1'b0);
        tick();
        rd_e = 7; rs2_d = 7;
        #1;
        chk_stall("load_use", 1'b1);
        chk("load_flush_e", {31'd0, flush_e}, 32'd1);
        chk("load_flush_d", {31'd0, flush_d}, 32'd0);
        tick();
        result_src_e = 3'b000;
        #1;
        chk_stall("load_done", 1'b0);
        chk("load_done_flush_e", {31'd0, flush_e}, 32'd0);
        chk("load_stall_count", stall_count, 32'd1);
        rd_e = 0; rs2_d = 0;

        // Input wait: 3 blocked cycles, then advance
        tick();
        in_issued_d = 1; in_valid = 0;
        #1;
        chk_stall("in_idle_blocked", 1'b1);
        tick();
        #1;
        chk_stall("in_wait1", 1'b1);
        chk("in_wait1_pop", {31'd0, in_pop}, 32'd0);
        tick();
        #1;
        chk_stall("in_wait2", 1'b1);
        tick();
        in_valid = 1;
        #1;
        chk_stall("in_advance", 1'b0);
        chk("in_advance_pop", {31'd0, in_pop}, 32'd0);
        tick();
        #1;
        chk("in_cool_pop", {31'd0, in_pop}, 32'd1);
        chk_stall("in_cool_next_in", 1'b1);
        chk("in_stall_count", stall_count, 32'd4);
        tick();
        #1;
        chk("in_after_cool_pop", {31'd0, in_pop}, 32'd0);
        chk_stall("in_second_adv", 1'b0);
        tick();
        in_issued_d = 0;
        #1;
        chk("in_second_pop", {31'd0, in_pop}, 32'd1);
        chk_stall("in_cool_empty", 1'b0);
        chk("in_stall_count2", stall_count, 32'd5);
        tick();
        #1;
        chk("in_pop_cleared", {31'd0, in_pop}, 32'd0);
        chk("in_no_push", {31'd0, out_push}, 32'd0);

        // Branch flushes a blocked out in IDLE
        out_issued_d = 1; out_ready = 0; pc_src_e = 1;
        #1;
        chk("br_flush_d", {31'd0, flush_d}, 32'd1);
        chk("br_flush_e", {31'd0, flush_e}, 32'd1);
        chk_stall("br_idle", 1'b0);
        tick();
        pc_src_e = 0; out_issued_d = 0;
        #1;
        chk_stall("br_back_idle", 1'b0);
        chk("br_no_push", {31'd0, out_push}, 32'd0);
        tick();
        #1;
        chk("br_no_push2", {31'd0, out_push}, 32'd0);

        // Branch while waiting in WAIT_OUT
        out_issued_d = 1;
        #1;
        chk_stall("out_blocked", 1'b1);
        tick();
        pc_src_e = 1;
        #1;
        chk_stall("out_wait_branch", 1'b0);
        chk("out_wait_flush_d", {31'd0, flush_d}, 32'd1);
        tick();
        pc_src_e = 0; out_issued_d = 0; out_ready = 1;
        #1;
        chk_stall("out_br_idle", 1'b0);
        tick();
        #1;
        chk("out_br_no_push", {31'd0, out_push}, 32'd0);

        // Plain output push
        out_issued_d = 1;
        #1;
        chk_stall("out_ready_adv", 1'b0);
        tick();
        out_issued_d = 0;
        #1;
        chk("out_push_one", {31'd0, out_push}, 32'd1);
        tick();
        #1;
        chk("out_push_cleared", {31'd0, out_push}, 32'd0);
        chk("out_stall_count", stall_count, 32'd6);

        // Timeout after 4 wait cycles
        in_issued_d = 1; in_valid = 0;
        tick();
        #1;
        chk("to_wait1", {31'd0, io_timeout}, 32'd0);
        tick();
        #1;
        chk("to_wait2", {31'd0, io_timeout}, 32'd0);
        tick();
        #1;
        chk("to_wait3", {31'd0, io_timeout}, 32'd0);
        tick();
        #1;
        chk("to_wait4", {31'd0, io_timeout}, 32'd1);
        chk_stall("to_wait4", 1'b1);
        tick();
        in_valid = 1;
        #1;
        chk("to_sticky_valid", {31'd0, io_timeout}, 32'd1);
        chk("to_stall_count", stall_count, 32'd11);
        tick();
        in_issued_d = 0;
        #1;
        chk("to_pop", {31'd0, in_pop}, 32'd1);
        chk("to_sticky_cool", {31'd0, io_timeout}, 32'd1);
        tick();
        #1;
        chk("to_sticky_idle", {31'd0, io_timeout}, 32'd1);

        // Asynchronous reset in the middle of WAIT_OUT
        out_issued_d = 1; out_ready = 0;
        tick();
        tick();
        #1;
        chk("ar_pre_count", stall_count, 32'd13);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_in_pop", {31'd0, in_pop}, 32'd0);
        chk("ar_out_push", {31'd0, out_push}, 32'd0);
        chk("ar_timeout", {31'd0, io_timeout}, 32'd0);
        chk("ar_stall_count", stall_count, 32'd0);
        out_issued_d = 0;
        #1;
        rst = 1'b0;
        #1;
        chk_stall("ar_idle", 1'b0);
        tick();
        out_ready = 1;
        #1;
        chk("ar_no_push", {31'd0, out_push}, 32'd0);
        tick();
        #1;
        chk("ar_no_push2", {31'd0, out_push}, 32'd0);
        chk("ar_timeout_after", {31'd0, io_timeout}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_io_sched.md
Name: hazard_io_sched

Overview:
- Pipeline scheduler for the 5-stage core: forwarding selects, load-use stalls, taken-branch flushes, and sequencing of in/out instructions against the I/O FIFOs.
- Consumes the control bundles carried in the decode, execute and memory stages, plus the writeback register-write info.
- Drives stall/flush enables of the F/D and D/E pipeline registers.
- Issues one-cycle pop/push strobes to the I/O FIFOs.

Parameters:
- LOAD_SRC, 3'b001: result_src encoding that marks a load.
- TIMEOUT, 1024: number of consecutive I/O-wait cycles before io_timeout is raised.
- CNT_W, 32: width of stall_count.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rs1_d, rs2_d  in  5 each  source registers in decode
- rs1_e, rs2_e, rd_e  in  5 each  source/destination registers in execute
- result_src_e  in  3  execute-stage result_src
- pc_src_e  in  1  branch/jump taken, resolved in execute
- rd_m, reg_write_m  in  5, 1  memory-stage destination and write enable
- rd_w, reg_write_w  in  5, 1  writeback-stage destination and write enable
- in_issued_d, out_issued_d  in  1 each  decode holds an in/out instruction
- in_valid  in  1  input FIFO non-empty
- out_ready  in  1  output FIFO not full
- forward_a_e, forward_b_e  out  2 each  00 register file, 10 from mem stage, 01 from wb stage
- stall_f, stall_d  out  1 each  hold PC / hold F/D register
- flush_d, flush_e  out  1 each  bubble F/D / D/E register
- in_pop, out_push  out  1 each  registered one-cycle FIFO strobes
- io_timeout  out  1  sticky wait-timeout flag
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Forwarding (combinational):
  - forward_a_e = 10 if reg_write_m && rd_m!=0 && rd_m==rs1_e.
  - Else 01 if reg_write_w && rd_w!=0 && rd_w==rs1_e.
  - Else 00.
  - forward_b_e is identical using rs2_e. The mem stage wins over wb.
- load_stall = (result_src_e==LOAD_SRC) && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d).
- FSM states: IDLE, COOL, WAIT_IN, WAIT_OUT.
  - COOL is the single cycle after a strobe. FIFO flags are not yet updated, so any in/out in decode is stalled.
- io_stall (combinational, in state IDLE):
  - (in_issued_d && !in_valid) || (out_issued_d && !out_ready)
- io_stall in other states:
  - COOL: in_issued_d || out_issued_d
  - WAIT_IN: !in_valid
  - WAIT_OUT: !out_ready
- An in/out instruction advances when io_stall=0, load_stall=0 and pc_src_e=0 in a state other than COOL. That cycle:
  - in_pop or out_push is registered to 1 for exactly the next cycle.
  - FSM goes to COOL.
- Transitions from IDLE:
  - in_issued_d && !in_valid && !pc_src_e -> WAIT_IN.
  - out_issued_d && !out_ready && !pc_src_e -> WAIT_OUT.
- COOL always exits next cycle: to IDLE, or to WAIT_* if a new in/out is blocked.
- Combined stall: stall = (load_stall || io_stall) && !pc_src_e.
  - stall_f = stall_d = stall.
  - flush_e = stall || pc_src_e.
  - flush_d = pc_src_e.
- Taken branch priority: a branch flushes decode. The waiting instruction is discarded, so the FSM returns to IDLE and no strobe is issued.
- Simultaneous in_issued_d and out_issued_d: not legal decode output. in_issued_d takes priority.
- Timeout:
  - Wait counter increments each cycle in WAIT_IN/WAIT_OUT and clears in any other state.
  - When it reaches TIMEOUT, io_timeout goes to 1 and stays 1 until reset. The stall continues.
- stall_count increments on every cycle with stall=1 and saturates at all-ones.
- Reset (asynchronous): FSM=IDLE; in_pop=out_push=io_timeout=0; stall_count=0; wait counter=0.
  - Combinational outputs follow inputs during reset. Reset mid-wait drops the pending I/O with no strobe.

Test Plan:
- rd_m=5, reg_write_m=1, rd_w=5, reg_write_w=1, rs1_e=5 -> forward_a_e=10. Then reg_write_m=0 -> 01. rs1_e=0 with rd=0 -> 00.
- result_src_e=001, rd_e=7, rs2_d=7 -> stall_f=stall_d=flush_e=1 for one cycle. Then result_src_e=000 -> all 0, stall_count=1.
- in_issued_d=1, in_valid=0 for 3 cycles then 1 -> 3 stall cycles in WAIT_IN, in_pop=1 exactly one cycle after advance, COOL stalls a following in.
- out_issued_d=1, out_ready=0 while pc_src_e=1 -> flush_d=flush_e=1, stall=0, FSM IDLE, out_push never asserted.
- TIMEOUT=4, in_valid held 0 -> io_timeout=1 on the 4th wait cycle. It stays 1 after in_valid=1 and clears only on rst.
- rst asserted asynchronously mid WAIT_OUT -> FSM IDLE, in_pop/out_push/io_timeout/stall_count=0 immediately.
